// File: rtl/data_path_gen2_pkg.sv
// Shared types for the second-generation K&S data path: decoded instruction
// set, ALU operation and PC source encodings, flag bundle and opcodes.
package data_path_gen2_pkg;

    typedef enum logic [4:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_XOR,
        I_SHL,
        I_SHR,
        I_BRANCH,
        I_BZERO,
        I_BNEG,
        I_BOV,
        I_BNOV,
        I_BNNEG,
        I_BNZERO,
        I_CALL,
        I_RET,
        I_HALT
    } decoded_instruction_type;

    typedef enum logic [2:0] {
        ALU_OR     = 3'b000,
        ALU_ADD    = 3'b001,
        ALU_SUB    = 3'b010,
        ALU_AND    = 3'b011,
        ALU_XOR    = 3'b100,
        ALU_SHL    = 3'b101,
        ALU_SHR    = 3'b110,
        ALU_PASS_A = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_INC  = 2'b00,
        PC_MEM  = 2'b01,
        PC_LINK = 2'b10,
        PC_HOLD = 2'b11
    } pc_src_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic uovf;
        logic sovf;
    } flags_t;

    localparam logic [7:0] OP_LOAD   = 8'h81;
    localparam logic [7:0] OP_STORE  = 8'h82;
    localparam logic [7:0] OP_MOVE   = 8'h91;
    localparam logic [7:0] OP_ADD    = 8'hA1;
    localparam logic [7:0] OP_SUB    = 8'hA2;
    localparam logic [7:0] OP_AND    = 8'hA3;
    localparam logic [7:0] OP_OR     = 8'hA4;
    localparam logic [7:0] OP_XOR    = 8'hA5;
    localparam logic [7:0] OP_SHL    = 8'hA6;
    localparam logic [7:0] OP_SHR    = 8'hA7;
    localparam logic [7:0] OP_BRANCH = 8'h01;
    localparam logic [7:0] OP_BZERO  = 8'h02;
    localparam logic [7:0] OP_BNEG   = 8'h03;
    localparam logic [7:0] OP_BOV    = 8'h05;
    localparam logic [7:0] OP_BNOV   = 8'h06;
    localparam logic [7:0] OP_BNNEG  = 8'h0A;
    localparam logic [7:0] OP_BNZERO = 8'h0B;
    localparam logic [7:0] OP_CALL   = 8'h0C;
    localparam logic [7:0] OP_RET    = 8'h0D;
    localparam logic [7:0] OP_HALT   = 8'hFF;

endpackage

// File: rtl/data_path_gen2_alu.sv
// Combinational ALU for the K&S data path: result plus raw zero/negative
// and unsigned/signed overflow flags.
module data_path_alu
    import data_path_gen2_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  alu_op_t           op_i,
    output logic [DATA_W-1:0] result_o,
    output flags_t            flags_o
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] result;
    logic              uovf;
    logic              sovf;

    // The extra top bit of the widened sum/difference is carry out / borrow.
    always_comb begin
        sum    = {1'b0, a_i} + {1'b0, b_i};
        diff   = {1'b0, a_i} - {1'b0, b_i};
        result = a_i;
        uovf   = 1'b0;
        sovf   = 1'b0;
        case (op_i)
            ALU_OR:  result = a_i | b_i;
            ALU_ADD: begin
                result = sum[DATA_W-1:0];
                uovf   = sum[DATA_W];
                sovf   = (a_i[MSB] == b_i[MSB]) && (result[MSB] != a_i[MSB]);
            end
            ALU_SUB: begin
                result = diff[DATA_W-1:0];
                uovf   = diff[DATA_W];
                sovf   = (a_i[MSB] != b_i[MSB]) && (result[MSB] != a_i[MSB]);
            end
            ALU_AND: result = a_i & b_i;
            ALU_XOR: result = a_i ^ b_i;
            ALU_SHL: begin
                result = {a_i[DATA_W-2:0], 1'b0};
                uovf   = a_i[MSB];
            end
            ALU_SHR: begin
                result = {1'b0, a_i[DATA_W-1:1]};
                uovf   = a_i[0];
            end
            default: result = a_i;
        endcase
    end

    assign result_o = result;
    assign flags_o  = '{zero: ~|result, neg: result[MSB], uovf: uovf, sovf: sovf};

endmodule

// File: rtl/data_path_gen2.sv
// Parametrised K&S data path: PC, link register, IR and decoder, 4-entry
// register file, ALU and flags, between the control unit and the RAM.
module data_path_gen2
    import data_path_gen2_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              pc_src,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    link_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [2:0]              operation,
    input  logic                    write_reg_enable,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       data_out,
    input  logic [DATA_W-1:0]       data_in
);

    if (DATA_W < 16 || DATA_W > 32 || ADDR_W + 2 > DATA_W - 8) begin : g_param_check
        $error("data_path_gen2: illegal DATA_W/ADDR_W combination");
    end

    logic [ADDR_W-1:0] pc_q, pc_d, link_q, link_d, pc_plus1, mem_addr;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] rf_q [4];
    logic [DATA_W-1:0] rf_d [4];
    flags_t            flags_q, flags_d, alu_flags;
    logic [1:0]        a_addr, b_addr, c_addr;
    logic [DATA_W-1:0] bus_a, bus_b, bus_c, alu_out;
    logic [7:0]        opcode;
    logic              ir_unused;

    assign opcode    = ir_q[DATA_W-1 -: 8];
    assign ir_unused = ^ir_q;

    always_comb begin
        decoded_instruction = I_NOP;
        a_addr   = 2'd0;
        b_addr   = 2'd0;
        c_addr   = 2'd0;
        mem_addr = '0;
        case (opcode)
            OP_LOAD: begin
                decoded_instruction = I_LOAD;
                c_addr   = ir_q[ADDR_W+1:ADDR_W];
                mem_addr = ir_q[ADDR_W-1:0];
            end
            OP_STORE: begin
                decoded_instruction = I_STORE;
                a_addr   = ir_q[ADDR_W+1:ADDR_W];
                mem_addr = ir_q[ADDR_W-1:0];
            end
            OP_MOVE: begin
                decoded_instruction = I_MOVE;
                c_addr = ir_q[3:2];
                a_addr = ir_q[1:0];
                b_addr = ir_q[1:0];
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                a_addr = ir_q[1:0];
                b_addr = ir_q[3:2];
                c_addr = ir_q[5:4];
                case (opcode)
                    OP_ADD:  decoded_instruction = I_ADD;
                    OP_SUB:  decoded_instruction = I_SUB;
                    OP_AND:  decoded_instruction = I_AND;
                    OP_OR:   decoded_instruction = I_OR;
                    OP_XOR:  decoded_instruction = I_XOR;
                    OP_SHL:  decoded_instruction = I_SHL;
                    default: decoded_instruction = I_SHR;
                endcase
            end
            OP_BRANCH, OP_BZERO, OP_BNEG, OP_BOV, OP_BNOV, OP_BNNEG, OP_BNZERO, OP_CALL: begin
                mem_addr = ir_q[ADDR_W-1:0];
                case (opcode)
                    OP_BRANCH: decoded_instruction = I_BRANCH;
                    OP_BZERO:  decoded_instruction = I_BZERO;
                    OP_BNEG:   decoded_instruction = I_BNEG;
                    OP_BOV:    decoded_instruction = I_BOV;
                    OP_BNOV:   decoded_instruction = I_BNOV;
                    OP_BNNEG:  decoded_instruction = I_BNNEG;
                    OP_BNZERO: decoded_instruction = I_BNZERO;
                    default:   decoded_instruction = I_CALL;
                endcase
            end
            OP_RET:  decoded_instruction = I_RET;
            OP_HALT: decoded_instruction = I_HALT;
            default: decoded_instruction = I_NOP;
        endcase
    end

    assign bus_a = rf_q[a_addr];
    assign bus_b = rf_q[b_addr];
    assign bus_c = c_sel ? alu_out : data_in;

    data_path_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i      (bus_a),
        .b_i      (bus_b),
        .op_i     (alu_op_t'(operation)),
        .result_o (alu_out),
        .flags_o  (alu_flags)
    );

    // Link always captures the pre-edge PC+1, so CALL can load link and PC together.
    assign pc_plus1 = pc_q + ADDR_W'(1);

    always_comb begin
        pc_d    = pc_q;
        link_d  = link_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        rf_d    = rf_q;
        if (pc_enable) begin
            case (pc_src)
                PC_INC:  pc_d = pc_plus1;
                PC_MEM:  pc_d = mem_addr;
                PC_LINK: pc_d = link_q;
                default: pc_d = pc_q;
            endcase
        end
        if (link_enable)      link_d         = pc_plus1;
        if (ir_enable)        ir_d           = data_in;
        if (flags_reg_enable) flags_d        = alu_flags;
        if (write_reg_enable) rf_d[c_addr]   = bus_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            link_q  <= '0;
            ir_q    <= '0;
            flags_q <= '0;
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            link_q  <= link_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign ram_addr          = addr_sel ? pc_q : mem_addr;
    assign data_out          = bus_a;
    assign zero_op           = flags_q.zero;
    assign neg_op            = flags_q.neg;
    assign unsigned_overflow = flags_q.uovf;
    assign signed_overflow   = flags_q.sovf;

endmodule

// File: doc/data_path_gen2.md
Name: data_path_gen2

Overview:
- Parametrised successor of the K&S processor data path: PC, IR, 4-entry register file, ALU, flags register and instruction decoder.
- Adds configurable data width (DATA_W) and memory address width (ADDR_W).
- Adds three ALU ops (XOR, SHL, SHR) and a single-entry link register that supports CALL/RET.
- Sits between the control unit (FSM, supplies enables and selects) and the unified program/data RAM.

Parameters:
- DATA_W, 16, data/instruction width; legal range 16..32.
- ADDR_W, 5, RAM address and PC width; legal when ADDR_W+2 <= DATA_W-8. Checked by an elaboration-time assertion.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_src  in  2  PC next source: 00 PC+1, 01 mem_addr, 10 link, 11 hold.
- pc_enable  in  1  PC update strobe.
- ir_enable  in  1  IR load from data_in.
- link_enable  in  1  link <= PC+1.
- addr_sel  in  1  ram_addr mux: 1 = PC, 0 = mem_addr.
- c_sel  in  1  bus_c mux: 1 = ALU out, 0 = data_in.
- operation  in  3  ALU op (alu_op_t).
- write_reg_enable  in  1  register file write strobe.
- flags_reg_enable  in  1  flags register load strobe.
- decoded_instruction  out  decoded_instruction_type  decoded current IR.
- zero_op, neg_op, unsigned_overflow, signed_overflow  out  1 each  registered flags.
- ram_addr  out  ADDR_W  RAM address.
- data_out  out  DATA_W  store data (= bus_a).
- data_in  in  DATA_W  RAM read data.

Behaviour:
- Reset (rst=1, async): PC, IR, link, r0..r3 and all four flags go to 0. IR=0 decodes to I_NOP. Release is synchronous to clk.
- Instruction fields:
  - opcode = IR[DATA_W-1 -: 8].
  - LOAD/STORE: reg = IR[ADDR_W+1:ADDR_W]; addr = IR[ADDR_W-1:0].
  - MOVE: c = IR[3:2]; a = b = IR[1:0].
  - ALU instructions: a = IR[1:0], b = IR[3:2], c = IR[5:4].
  - Branches, CALL: mem_addr = IR[ADDR_W-1:0].
  - Unused address fields decode to 0.
- Opcodes:
  - LOAD 0x81, STORE 0x82, MOVE 0x91.
  - ADD 0xA1, SUB 0xA2, AND 0xA3, OR 0xA4, XOR 0xA5, SHL 0xA6, SHR 0xA7.
  - BRANCH 0x01, BZERO 0x02, BNEG 0x03, BOV 0x05, BNOV 0x06, BNNEG 0x0A, BNZERO 0x0B, CALL 0x0C, RET 0x0D.
  - HALT 0xFF. All other opcodes decode to NOP.
- Decoder is purely combinational from IR.
- Register file:
  - Combinational read on bus_a and bus_b.
  - Write of bus_c to r[c_addr] on the posedge when write_reg_enable=1.
  - Read-during-write returns the old value.
- ALU (combinational, DATA_W wide):
  - 000 OR, 001 ADD, 010 SUB, 011 AND, 100 XOR.
  - 101 SHL: a<<1, LSB filled with 0.
  - 110 SHR: a>>1 logical.
  - 111 PASS_A.
- Flags:
  - zero = ~|alu_out; neg = alu_out[DATA_W-1].
  - ADD: unsigned_ovf = carry out; signed_ovf = (a[msb]==b[msb]) && (res[msb]!=a[msb]).
  - SUB: unsigned_ovf = borrow (a<b unsigned); signed_ovf = (a[msb]!=b[msb]) && (res[msb]!=a[msb]).
  - SHL: unsigned_ovf = a[msb]. SHR: unsigned_ovf = a[0]. Both shifts: signed_ovf = 0.
  - Logic ops and PASS_A: both overflow flags 0.
  - All four flags load together on the posedge when flags_reg_enable=1; otherwise they hold.
- PC:
  - Updates only when pc_enable=1.
  - PC+1 wraps modulo 2^ADDR_W (e.g. 31 -> 0 for ADDR_W=5).
  - pc_src=11 with pc_enable=1 holds the PC.
- Link:
  - link_enable=1 loads (PC+1) mod 2^ADDR_W, computed from the pre-edge PC.
  - Simultaneous link_enable and pc_enable with pc_src=01 (CALL): link captures the old PC+1 and PC takes mem_addr, in the same edge.
- IR loads data_in when ir_enable=1; independent of PC.
- bus_c = c_sel ? alu_out : data_in. ram_addr = addr_sel ? PC : mem_addr. data_out = bus_a.
- Reset asserted mid-instruction clears all state immediately, with no clock edge required. Outputs are valid combinationally from reset state (ram_addr = 0 when addr_sel=1).

Decomposition:
- k_and_s_pkg additions:
  - decoded_instruction_type gains I_XOR, I_SHL, I_SHR, I_CALL, I_RET.
  - New alu_op_t enum (3 bits).
  - New pc_src_t enum (2 bits).
  - localparam opcode constants.
- One sub-module: data_path_alu. Combinational, parametrised by DATA_W; outputs result plus the four raw flags.
- Decoder, register file, PC/link and flags stay in data_path_gen2.

Test Plan:
- Reset: assert rst mid-run with r1=0x1234 and PC=7 → immediately PC=0, all registers 0, flags 0, decoded_instruction=I_NOP.
- ADD overflow (DATA_W=16): r0=0x7FFF, r1=0x0001, ADD c=2 → r2=0x8000, neg=1, signed_ovf=1, unsigned_ovf=0, zero=0.
- SUB borrow: r0=5, r1=7, SUB (a=r0, b=r1) → result 0xFFFE, unsigned_ovf=1, signed_ovf=0, neg=1.
- SHL/SHR: r0=0x8001; SHL → 0x0002 with unsigned_ovf=1; SHR → 0x4000 with unsigned_ovf=1.
- CALL/RET: PC=3, IR=CALL 0x14, link_enable=1 with pc_src=01 → PC=20, link=4; later pc_src=10 → PC=4. PC=31 with PC+1 → PC=0.
- Parametric (DATA_W=24, ADDR_W=8): LOAD opcode in IR[23:16], reg field IR[9:8], addr IR[7:0]=0xC3 → ram_addr=0xC3 with addr_sel=0, destination register written from data_in.
